// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM encodings and
// decimal-correction constants.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [3:0] BCD_NIBBLE_MAX = 4'd9;
   localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
   localparam logic [3:0] BCD_ADJ_VAL    = 4'd3;

   function automatic logic nibble_bad(input logic [3:0] nib);
      return nib > BCD_NIBBLE_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction after a right shift: a digit that received a bit worth 5
// from its upper neighbour shows up as >= 8 and is pulled back by 3.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= BCD_ADJ_THRESH) ? din - BCD_ADJ_VAL : din;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble), one bit per clock,
// with invalid-digit detection and saturation on overflow.
module bcd_to_binary_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS    = 3,
   parameter int BIN_WIDTH = 10
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [4*DIGITS-1:0]    bcd,
   output logic                   ready,
   output logic                   done,
   output logic [BIN_WIDTH-1:0]   bin,
   output logic                   invalid,
   output logic                   overflow
);

   localparam int DW = 4 * DIGITS;
   localparam int CW = $clog2(BIN_WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(BIN_WIDTH);

   state_t           state;
   logic [DW-1:0]    dreg;
   logic [DW-1:0]    dreg_sh;
   logic [DW-1:0]    dreg_adj;
   logic [BIN_WIDTH-1:0] breg;
   logic [CW-1:0]    count;
   logic             bad;

   assign dreg_sh = dreg >> 1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .din  (dreg_sh[4*g +: 4]),
         .dout (dreg_adj[4*g +: 4])
      );
   end

   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) bad = bad | nibble_bad(bcd[4*i +: 4]);
   end

   // An invalid word spends one SHIFT cycle zeroing the registers and jumping the
   // counter to terminal, so completion reports bin=0 with no overflow.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         ready    <= 1'b1;
         done     <= 1'b0;
         bin      <= '0;
         invalid  <= 1'b0;
         overflow <= 1'b0;
         dreg     <= '0;
         breg     <= '0;
         count    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  dreg     <= bcd;
                  breg     <= '0;
                  count    <= '0;
                  invalid  <= bad;
                  overflow <= 1'b0;
                  ready    <= 1'b0;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (count == LAST) begin
                  overflow <= (dreg != '0);
                  bin      <= (dreg != '0) ? '1 : breg;
                  done     <= 1'b1;
                  state    <= ST_DONE;
               end else if (invalid) begin
                  dreg  <= '0;
                  breg  <= '0;
                  count <= LAST;
               end else begin
                  dreg  <= dreg_adj;
                  breg  <= {dreg[0], breg[BIN_WIDTH-1:1]};
                  count <= count + 1'b1;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= ST_IDLE;
            end
            default: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Randomized and directed bench for bcd_to_binary_seq against a decimal reference,
// covering a 3-digit and a 4-digit instance.
module tb_bcd_to_binary_seq;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start3 = 1'b0, start4 = 1'b0;
   logic [11:0] bcd3 = '0;
   logic [15:0] bcd4 = '0;
   logic        ready3, done3, invalid3, overflow3;
   logic        ready4, done4, invalid4, overflow4;
   logic [9:0]  bin3, bin4;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   bcd_to_binary_seq #(.DIGITS(3), .BIN_WIDTH(10)) u_dut3 (
      .clock(clock), .reset_n(reset_n), .start(start3), .bcd(bcd3),
      .ready(ready3), .done(done3), .bin(bin3), .invalid(invalid3), .overflow(overflow3)
   );

   bcd_to_binary_seq #(.DIGITS(4), .BIN_WIDTH(10)) u_dut4 (
      .clock(clock), .reset_n(reset_n), .start(start4), .bcd(bcd4),
      .ready(ready4), .done(done4), .bin(bin4), .invalid(invalid4), .overflow(overflow4)
   );

   // Decimal reference: value of the digits, invalid if any digit > 9, saturate at 1024.
   function automatic void model(input bit use4, input logic [15:0] val,
                                 output logic [9:0] eb, output logic ei, output logic eo);
      int nd, v, p;
      logic [3:0] nib;
      nd = use4 ? 4 : 3;
      v = 0; p = 1; ei = 1'b0;
      for (int i = 0; i < nd; i++) begin
         nib = val[4*i +: 4];
         if (nib > 4'd9) ei = 1'b1;
         v += int'(nib) * p;
         p *= 10;
      end
      if (ei) begin eb = '0; eo = 1'b0; end
      else if (v >= 1024) begin eb = '1; eo = 1'b1; end
      else begin eb = v[9:0]; eo = 1'b0; end
   endfunction

   function automatic logic [15:0] rand_valid(input int nd);
      logic [15:0] w;
      w = '0;
      for (int i = 0; i < nd; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
      return w;
   endfunction

   // Waits for ready, issues one start, scrambles bcd after accept, returns the
   // number of clocks from the accept edge to done (0 if none within the bound).
   task automatic convert(input bit use4, input logic [15:0] val, output int lat);
      @(negedge clock);
      for (int w = 0; w < 30 && ((use4 ? ready4 : ready3) !== 1'b1); w++) @(negedge clock);
      if (use4) begin bcd4 = val; start4 = 1'b1; end
      else begin bcd3 = val[11:0]; start3 = 1'b1; end
      @(posedge clock); #1;
      start3 = 1'b0; start4 = 1'b0;
      bcd3 = 12'($urandom); bcd4 = 16'($urandom);
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clock); #1;
         if ((use4 ? done4 : done3) === 1'b1) begin lat = c; break; end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({ready3, done3, bin3, invalid3, overflow3} !== {1'b1, 1'b0, 10'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset3: ready=%b done=%b bin=%0d inv=%b ovf=%b, want 1 0 0 0 0",
                  ready3, done3, bin3, invalid3, overflow3);
      end
      checks++;
      if ({ready4, done4, bin4, invalid4, overflow4} !== {1'b1, 1'b0, 10'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset4: ready=%b done=%b bin=%0d inv=%b ovf=%b, want 1 0 0 0 0",
                  ready4, done4, bin4, invalid4, overflow4);
      end
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [11:0] vals [4] = '{12'h255, 12'h999, 12'h000, 12'h001};
      logic [9:0]  exps [4] = '{10'd255, 10'h3E7, 10'd0, 10'd1};
      int lat;
      for (int i = 0; i < 4; i++) begin
         convert(1'b0, {4'h0, vals[i]}, lat);
         checks++;
         if ({bin3, invalid3, overflow3} !== {exps[i], 1'b0, 1'b0} || lat != 11) begin
            errors++;
            $display("FAIL directed %h: bin=%0d inv=%b ovf=%b lat=%0d, want bin=%0d 0 0 lat=11",
                     vals[i], bin3, invalid3, overflow3, lat, exps[i]);
         end
      end
   endtask

   task automatic test_invalid();
      int lat;
      logic [15:0] w;
      convert(1'b0, 16'h01A3, lat);
      checks++;
      if ({bin3, invalid3, overflow3} !== {10'd0, 1'b1, 1'b0} || lat != 2) begin
         errors++;
         $display("FAIL invalid 1A3: bin=%0d inv=%b ovf=%b lat=%0d, want 0 1 0 lat=2",
                  bin3, invalid3, overflow3, lat);
      end
      for (int i = 0; i < 10; i++) begin
         w = rand_valid(3);
         w[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
         convert(1'b0, w, lat);
         checks++;
         if ({bin3, invalid3, overflow3} !== {10'd0, 1'b1, 1'b0} || lat != 2) begin
            errors++;
            $display("FAIL invalid %h: bin=%0d inv=%b ovf=%b lat=%0d, want 0 1 0 lat=2",
                     w[11:0], bin3, invalid3, overflow3, lat);
         end
      end
   endtask

   task automatic test_overflow();
      int lat;
      logic [15:0] w;
      logic [9:0] eb;
      logic ei, eo;
      convert(1'b1, 16'h1024, lat);
      checks++;
      if ({bin4, invalid4, overflow4} !== {10'h3FF, 1'b0, 1'b1} || lat != 11) begin
         errors++;
         $display("FAIL ovf 1024: bin=%h inv=%b ovf=%b lat=%0d, want 3ff 0 1 lat=11",
                  bin4, invalid4, overflow4, lat);
      end
      convert(1'b1, 16'h1023, lat);
      checks++;
      if ({bin4, invalid4, overflow4} !== {10'h3FF, 1'b0, 1'b0} || lat != 11) begin
         errors++;
         $display("FAIL ovf 1023: bin=%h inv=%b ovf=%b lat=%0d, want 3ff 0 0 lat=11",
                  bin4, invalid4, overflow4, lat);
      end
      for (int i = 0; i < 100; i++) begin
         w = (i % 2 == 0) ? rand_valid(4) : 16'($urandom);
         model(1'b1, w, eb, ei, eo);
         convert(1'b1, w, lat);
         checks++;
         if ({bin4, invalid4, overflow4} !== {eb, ei, eo} || lat != (ei ? 2 : 11)) begin
            errors++;
            $display("FAIL rand4 %h: bin=%h inv=%b ovf=%b lat=%0d, want %h %b %b",
                     w, bin4, invalid4, overflow4, lat, eb, ei, eo);
         end
      end
   endtask

   task automatic test_ignore_start();
      int ndone;
      logic [9:0] got;
      @(negedge clock);
      for (int w = 0; w < 30 && ready3 !== 1'b1; w++) @(negedge clock);
      bcd3 = 12'h123; start3 = 1'b1;
      @(posedge clock); #1;
      start3 = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++;
      if (ready3 !== 1'b0) begin
         errors++;
         $display("FAIL ready_in_shift: ready=%b, want 0", ready3);
      end
      bcd3 = 12'h456; start3 = 1'b1;
      @(posedge clock); #1;
      start3 = 1'b0;
      ndone = 0; got = '0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clock); #1;
         if (done3 === 1'b1) begin
            ndone++;
            if (ndone == 1) got = bin3;
         end
      end
      checks++;
      if (ndone != 1 || got !== 10'd123) begin
         errors++;
         $display("FAIL ignore_start: dones=%0d bin=%0d, want 1 and 123", ndone, got);
      end
   endtask

   task automatic test_reset_abort();
      int ndone;
      @(negedge clock);
      for (int w = 0; w < 30 && ready3 !== 1'b1; w++) @(negedge clock);
      bcd3 = 12'h999; start3 = 1'b1;
      @(posedge clock); #1;
      start3 = 1'b0;
      repeat (5) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      @(posedge clock); #1;
      checks++;
      if ({ready3, done3, bin3, invalid3, overflow3} !== {1'b1, 1'b0, 10'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_abort: ready=%b done=%b bin=%0d inv=%b ovf=%b, want 1 0 0 0 0",
                  ready3, done3, bin3, invalid3, overflow3);
      end
      @(negedge clock);
      reset_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clock); #1;
         if (done3 === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL abort_no_done: dones=%0d, want 0", ndone);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] expq[$];
      logic [9:0] eb;
      logic ei, eo;
      logic [15:0] w;
      int n, last_c, prev_done;
      @(negedge clock);
      for (int k = 0; k < 30 && ready3 !== 1'b1; k++) @(negedge clock);
      w = rand_valid(3);
      model(1'b0, w, eb, ei, eo);
      expq.push_back(eb);
      bcd3 = w[11:0]; start3 = 1'b1;
      n = 0; last_c = -1; prev_done = 0;
      for (int c = 0; c < 100 && n < 4; c++) begin
         @(posedge clock); #1;
         if (done3 === 1'b1) begin
            n++;
            eb = expq.pop_front();
            checks++;
            if (bin3 !== eb || ready3 !== 1'b0 || prev_done != 0) begin
               errors++;
               $display("FAIL b2b result %0d: bin=%0d ready=%b prev_done=%0d, want %0d 0 0",
                        n, bin3, ready3, prev_done, eb);
            end
            if (last_c >= 0) begin
               checks++;
               if (c - last_c != 13) begin
                  errors++;
                  $display("FAIL b2b spacing: got %0d cycles, want 13", c - last_c);
               end
            end
            last_c = c;
            w = rand_valid(3);
            model(1'b0, w, eb, ei, eo);
            expq.push_back(eb);
            bcd3 = w[11:0];
         end
         prev_done = (done3 === 1'b1) ? 1 : 0;
      end
      start3 = 1'b0;
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL b2b count: got %0d results, want 4", n);
      end
      @(posedge clock); #1;
      checks++;
      if (done3 !== 1'b0) begin
         errors++;
         $display("FAIL b2b pulse width: done=%b after one cycle, want 0", done3);
      end
   endtask

   task automatic test_sweep();
      int lat;
      logic [15:0] w;
      logic [9:0] eb;
      logic ei, eo;
      for (int v = 0; v < 1000; v++) begin
         w = {4'h0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
         model(1'b0, w, eb, ei, eo);
         convert(1'b0, w, lat);
         checks++;
         if ({bin3, invalid3, overflow3} !== {eb, ei, eo} || lat != 11) begin
            errors++;
            $display("FAIL sweep %h: bin=%0d inv=%b ovf=%b lat=%0d, want %0d %b %b lat=11",
                     w[11:0], bin3, invalid3, overflow3, lat, eb, ei, eo);
         end
      end
   endtask

   task automatic test_random();
      int lat;
      logic [15:0] w;
      logic [9:0] eb;
      logic ei, eo;
      for (int i = 0; i < 300; i++) begin
         w = {4'h0, 12'($urandom)};
         model(1'b0, w, eb, ei, eo);
         convert(1'b0, w, lat);
         checks++;
         if ({bin3, invalid3, overflow3} !== {eb, ei, eo} || lat != (ei ? 2 : 11)) begin
            errors++;
            $display("FAIL rand3 %h: bin=%0d inv=%b ovf=%b lat=%0d, want %0d %b %b",
                     w[11:0], bin3, invalid3, overflow3, lat, eb, ei, eo);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_invalid();
      test_overflow();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_random();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
